com_bus_arbiter_rr: RTL
=======================

Name: com_bus_arbiter_rr

Overview:
Parametrised successor of the fixed 8-proc/4-snoop common-bus arbiter. It grants the shared common bus (Address_Com/Data_Bus_Com) to exactly one requester among NUM_PROC processor-side cache controllers, NUM_SNOOP snoop responders and the memory snoop port. Requesters are served by class priority, with round-robin fairness inside each class. Grants are registered, and a holder keeps the bus until it drops its request. A watchdog flags over-long holds.

Parameters:
NUM_PROC, 8, number of processor-side requesters (1..16)
NUM_SNOOP, 4, number of snoop-side requesters (1..16)
MAX_HOLD, 64, cycles a holder may keep the grant before Hold_timeout fires; 0 disables the watchdog
ID_W, 5, width of Gnt_id; must satisfy 2**ID_W >= NUM_PROC+NUM_SNOOP+1

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
Com_Bus_Req_proc  input  NUM_PROC  processor-side requests, bit i = cache i
Com_Bus_Req_snoop  input  NUM_SNOOP  snoop-response requests
Mem_snoop_req  input  1  memory controller snoop request
Com_Bus_Gnt_proc  output  NUM_PROC  one-hot processor grant
Com_Bus_Gnt_snoop  output  NUM_SNOOP  one-hot snoop grant
Mem_snoop_gnt  output  1  memory snoop grant
Bus_busy  output  1  high while any grant is asserted
Gnt_id  output  ID_W  encoded holder: proc i -> i; snoop j -> NUM_PROC+j; mem -> NUM_PROC+NUM_SNOOP; 0 when idle
Hold_timeout  output  1  one-cycle pulse when the hold counter reaches MAX_HOLD

Behaviour:
- Reset (sampled at the clk edge): all grants 0, Bus_busy 0, Gnt_id 0, Hold_timeout 0, both RR pointers 0, hold counter 0, state IDLE. A reset that arrives mid-grant drops the grant at that edge, with no handoff.
- FSM states: IDLE, GNT_SNOOP, GNT_MEM, GNT_PROC, TURN.
- IDLE arbitration uses requests sampled at edge t; the grant is visible after edge t (1-cycle latency). No combinational path from req to gnt.
- Class priority: snoop > mem > proc. A pending snoop request is never blocked by a pending proc request.
- Within a class, round-robin: search starts at the pointer and wraps modulo the class size.
- On grant to index k, that class pointer becomes (k+1) mod size. The other class pointer is unchanged.
- Hold: the grant stays asserted while the holder's request is high. There is no preemption, including by snoops.
- Release: the holder's request is sampled low at edge t, so the grant drops after edge t. The FSM goes to TURN for exactly one cycle (bus turnaround, all grants 0), then IDLE arbitrates. The earliest next grant is after edge t+2.
- Requests from non-holders may change freely. Only the levels sampled in IDLE matter.
- Hold counter: cleared on every new grant, increments each cycle a grant is held, saturates at MAX_HOLD. Hold_timeout pulses on the cycle the counter first equals MAX_HOLD. The grant is not revoked.
- Invariant: at most one bit set across Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop and Mem_snoop_gnt, every cycle.
- Bus_busy = OR of all grants. Gnt_id is registered with the grants.
- Simultaneous events: if the holder drops its request while others are pending, the TURN rule still applies.
- Single-member class (size 1): the pointer stays 0.

Decomposition:
- Package com_bus_arb_pkg holds:
  - state enum arb_state_t {IDLE, GNT_SNOOP, GNT_MEM, GNT_PROC, TURN}
  - class enum gnt_class_t {CLS_NONE, CLS_SNOOP, CLS_MEM, CLS_PROC}
  - localparam function for the Gnt_id encoding
- Sub-module rr_pick #(WIDTH): combinational round-robin picker. Inputs req[WIDTH] and ptr. Outputs one-hot gnt, index and valid. It is instantiated once for proc and once for snoop.

Test Plan:
- Reset while Com_Bus_Req_proc=8'h01 is granted -> all grants 0 and Gnt_id=0 after the reset edge; the first grant after reset goes to proc0 one cycle after rst deasserts.
- Com_Bus_Req_proc=8'h81, each holder releasing after 3 cycles -> grant order proc0, proc7, proc0, with one TURN cycle between grants; Gnt_id 0, 7, 0.
- Com_Bus_Req_proc=8'h04 and Com_Bus_Req_snoop=4'h2 raised in the same cycle -> snoop1 granted first (Gnt_id=9); proc2 granted 2 cycles after snoop1 releases.
- proc3 held while snoop0 raises a request -> no preemption; snoop0 granted only after the proc3 release plus TURN.
- MAX_HOLD=4, proc1 held for 10 cycles -> a single Hold_timeout pulse on the 4th held cycle; grant unchanged throughout.
- Random requests on all 13 sources for 10k cycles -> one-hot invariant holds every cycle, and every continuously asserted proc request is granted within NUM_PROC grants.

Source files
------------

// File: rtl/com_bus_arb_pkg.sv
// rtl/com_bus_arb_pkg.sv - shared types and Gnt_id encoding for the common-bus arbiter
package com_bus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GNT_SNOOP,
        GNT_MEM,
        GNT_PROC,
        TURN
    } arb_state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_SNOOP,
        CLS_MEM,
        CLS_PROC
    } gnt_class_t;

    // Holder encoding: proc i -> i, snoop j -> num_proc+j, mem -> num_proc+num_snoop, none -> 0.
    function automatic int unsigned gnt_id_enc(input gnt_class_t cls, input int unsigned idx,
                                               input int unsigned num_proc,
                                               input int unsigned num_snoop);
        case (cls)
            CLS_PROC:  return idx;
            CLS_SNOOP: return num_proc + idx;
            CLS_MEM:   return num_proc + num_snoop;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/com_bus_arbiter_rr_rr_pick.sv
// rtl/com_bus_arbiter_rr_rr_pick.sv - combinational round-robin picker
// Ports: req  - request vector
//        ptr  - index where the search starts (wraps modulo WIDTH)
//        gnt  - one-hot pick, idx - its index, valid - any request present
module rr_pick #(
    parameter int WIDTH = 8,
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [WIDTH-1:0] gnt,
    output logic [PW-1:0]    idx,
    output logic             valid
);

    function automatic int wrap(input int p, input int o);
        return (p + o) % WIDTH;
    endfunction

    // Scan offsets from farthest to nearest so the last hit is the one closest to ptr.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[wrap(int'(ptr), i)]) begin
                gnt                     = '0;
                gnt[wrap(int'(ptr), i)] = 1'b1;
                idx                     = PW'(wrap(int'(ptr), i));
                valid                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/com_bus_arbiter_rr.sv
// rtl/com_bus_arbiter_rr.sv - common-bus arbiter: snoop > mem > proc, round-robin per class
// Ports: clk, rst (sync, active-high)
//        Com_Bus_Req_proc/Com_Bus_Req_snoop/Mem_snoop_req - requests
//        Com_Bus_Gnt_proc/Com_Bus_Gnt_snoop/Mem_snoop_gnt - registered one-hot grants
//        Bus_busy - any grant, Gnt_id - encoded holder, Hold_timeout - watchdog pulse
module com_bus_arbiter_rr #(
    parameter int NUM_PROC  = 8,
    parameter int NUM_SNOOP = 4,
    parameter int MAX_HOLD  = 64,
    parameter int ID_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
    input  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop,
    input  logic                 Mem_snoop_req,
    output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
    output logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop,
    output logic                 Mem_snoop_gnt,
    output logic                 Bus_busy,
    output logic [ID_W-1:0]      Gnt_id,
    output logic                 Hold_timeout
);
    import com_bus_arb_pkg::*;

    localparam int PPW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam int SPW = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;
    localparam int CW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    arb_state_t           state, state_n;
    logic [PPW-1:0]       proc_ptr, proc_ptr_n;
    logic [SPW-1:0]       snoop_ptr, snoop_ptr_n;
    logic [NUM_PROC-1:0]  gnt_proc, gnt_proc_n;
    logic [NUM_SNOOP-1:0] gnt_snoop, gnt_snoop_n;
    logic                 gnt_mem, gnt_mem_n;
    logic [ID_W-1:0]      gnt_id, gnt_id_n;
    logic [CW-1:0]        hold_cnt, hold_cnt_n;
    logic                 hold_to, hold_to_n;
    logic                 grant_new, held;

    logic [NUM_PROC-1:0]  pick_proc;
    logic [PPW-1:0]       pick_proc_idx;
    logic                 pick_proc_valid;
    logic [NUM_SNOOP-1:0] pick_snoop;
    logic [SPW-1:0]       pick_snoop_idx;
    logic                 pick_snoop_valid;

    rr_pick #(.WIDTH(NUM_PROC)) u_pick_proc (
        .req   (Com_Bus_Req_proc),
        .ptr   (proc_ptr),
        .gnt   (pick_proc),
        .idx   (pick_proc_idx),
        .valid (pick_proc_valid)
    );

    rr_pick #(.WIDTH(NUM_SNOOP)) u_pick_snoop (
        .req   (Com_Bus_Req_snoop),
        .ptr   (snoop_ptr),
        .gnt   (pick_snoop),
        .idx   (pick_snoop_idx),
        .valid (pick_snoop_valid)
    );

    always_comb begin
        state_n     = state;
        proc_ptr_n  = proc_ptr;
        snoop_ptr_n = snoop_ptr;
        gnt_proc_n  = gnt_proc;
        gnt_snoop_n = gnt_snoop;
        gnt_mem_n   = gnt_mem;
        gnt_id_n    = gnt_id;
        grant_new   = 1'b0;
        held        = 1'b0;
        case (state)
            IDLE: begin
                if (pick_snoop_valid) begin
                    state_n     = GNT_SNOOP;
                    gnt_snoop_n = pick_snoop;
                    snoop_ptr_n = (pick_snoop_idx == SPW'(NUM_SNOOP - 1)) ? '0
                                                                          : pick_snoop_idx + SPW'(1);
                    gnt_id_n    = ID_W'(gnt_id_enc(CLS_SNOOP, 32'(pick_snoop_idx),
                                                   NUM_PROC, NUM_SNOOP));
                    grant_new   = 1'b1;
                end else if (Mem_snoop_req) begin
                    state_n   = GNT_MEM;
                    gnt_mem_n = 1'b1;
                    gnt_id_n  = ID_W'(gnt_id_enc(CLS_MEM, 0, NUM_PROC, NUM_SNOOP));
                    grant_new = 1'b1;
                end else if (pick_proc_valid) begin
                    state_n    = GNT_PROC;
                    gnt_proc_n = pick_proc;
                    proc_ptr_n = (pick_proc_idx == PPW'(NUM_PROC - 1)) ? '0
                                                                       : pick_proc_idx + PPW'(1);
                    gnt_id_n   = ID_W'(gnt_id_enc(CLS_PROC, 32'(pick_proc_idx),
                                                  NUM_PROC, NUM_SNOOP));
                    grant_new  = 1'b1;
                end
            end
            GNT_SNOOP: held = |(Com_Bus_Req_snoop & gnt_snoop);
            GNT_MEM:   held = Mem_snoop_req;
            GNT_PROC:  held = |(Com_Bus_Req_proc & gnt_proc);
            TURN:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase

        // Leaving a grant state without the holder's request always passes through TURN.
        if ((state == GNT_SNOOP || state == GNT_MEM || state == GNT_PROC) && !held) begin
            state_n     = TURN;
            gnt_proc_n  = '0;
            gnt_snoop_n = '0;
            gnt_mem_n   = 1'b0;
            gnt_id_n    = '0;
        end

        // hold_cnt counts held cycles including the current one, so a new grant starts at 1.
        hold_to_n = 1'b0;
        if (grant_new) begin
            hold_cnt_n = (MAX_HOLD > 0) ? CW'(1) : '0;
            hold_to_n  = (HOLD_MAX == CW'(1));
        end else if (held) begin
            hold_cnt_n = hold_cnt;
            if (hold_cnt != HOLD_MAX) begin
                hold_cnt_n = hold_cnt + CW'(1);
                hold_to_n  = (hold_cnt + CW'(1) == HOLD_MAX);
            end
        end else begin
            hold_cnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            proc_ptr  <= '0;
            snoop_ptr <= '0;
            gnt_proc  <= '0;
            gnt_snoop <= '0;
            gnt_mem   <= 1'b0;
            gnt_id    <= '0;
            hold_cnt  <= '0;
            hold_to   <= 1'b0;
        end else begin
            state     <= state_n;
            proc_ptr  <= proc_ptr_n;
            snoop_ptr <= snoop_ptr_n;
            gnt_proc  <= gnt_proc_n;
            gnt_snoop <= gnt_snoop_n;
            gnt_mem   <= gnt_mem_n;
            gnt_id    <= gnt_id_n;
            hold_cnt  <= hold_cnt_n;
            hold_to   <= hold_to_n;
        end
    end

    assign Com_Bus_Gnt_proc  = gnt_proc;
    assign Com_Bus_Gnt_snoop = gnt_snoop;
    assign Mem_snoop_gnt     = gnt_mem;
    assign Bus_busy          = (|gnt_proc) | (|gnt_snoop) | gnt_mem;
    assign Gnt_id            = gnt_id;
    assign Hold_timeout      = hold_to;

endmodule
